// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Brief    : Stall/flush controller for load-use, taken-branch and
//            data-memory-wait hazards, with wait timeout and perf counters.
// Revision : 1.0
// ============================================================================
module hazard_stall_unit #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_Rs1_i,
    input  logic [4:0]       ID_Rs2_i,
    input  logic             ID_UseRs1_i,
    input  logic             ID_UseRs2_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_Rd_i,
    input  logic             ID_BranchTaken_i,
    input  logic             MEM_Req_i,
    input  logic             MEM_Ready_i,
    output logic             PC_Write_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             EXMEM_Write_o,
    output logic             MEMWB_Bubble_o,
    output logic             Mem_Timeout_o,
    output logic [CNT_W-1:0] Stall_Cnt_o,
    output logic [CNT_W-1:0] LoadUse_Cnt_o,
    output logic [CNT_W-1:0] Flush_Cnt_o
);

    localparam int                c_WAIT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] c_S_RUN  = 1'b0;
    localparam logic [0:0] c_S_WAIT = 1'b1;

    logic                r_state;
    logic                w_state_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_next;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_lu_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic w_mem_stall;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_flush;

    assign w_mem_stall = MEM_Req_i & ~MEM_Ready_i;
    assign w_rs1_hit   = ID_UseRs1_i & (ID_Rs1_i == EX_Rd_i);
    assign w_rs2_hit   = ID_UseRs2_i & (ID_Rs2_i == EX_Rd_i);
    assign w_load_use  = EX_MemRead_i & (EX_Rd_i != 5'd0) & (w_rs1_hit | w_rs2_hit);
    // Flush only when neither higher-priority hazard holds the front end
    assign w_flush     = ID_BranchTaken_i & ~w_mem_stall & ~w_load_use;

    always_comb begin
        PC_Write_o     = 1'b1;
        IFID_Write_o   = 1'b1;
        IFID_Flush_o   = 1'b0;
        IDEX_Bubble_o  = 1'b0;
        EXMEM_Write_o  = 1'b1;
        MEMWB_Bubble_o = 1'b0;
        if (rst_i) begin
            PC_Write_o     = 1'b0;
            IFID_Write_o   = 1'b0;
            IFID_Flush_o   = 1'b1;
            IDEX_Bubble_o  = 1'b1;
            EXMEM_Write_o  = 1'b0;
            MEMWB_Bubble_o = 1'b1;
        end else if (w_mem_stall) begin
            PC_Write_o     = 1'b0;
            IFID_Write_o   = 1'b0;
            EXMEM_Write_o  = 1'b0;
            MEMWB_Bubble_o = 1'b1;
        end else if (w_load_use) begin
            PC_Write_o     = 1'b0;
            IFID_Write_o   = 1'b0;
            IDEX_Bubble_o  = 1'b1;
        end else if (w_flush) begin
            IFID_Flush_o   = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        case (r_state)
            c_S_RUN: begin
                if (w_mem_stall) begin
                    w_state_next = c_S_WAIT;
                    w_wait_next  = c_WAIT_ONE;
                end
            end
            c_S_WAIT: begin
                if (w_mem_stall) begin
                    if (r_wait_cnt != c_WAIT_MAX) begin
                        w_wait_next = r_wait_cnt + c_WAIT_ONE;
                    end
                end else begin
                    w_state_next = c_S_RUN;
                    w_wait_next  = '0;
                end
            end
            default: begin
                w_state_next = c_S_RUN;
                w_wait_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_S_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_mem_stall && (w_wait_next == c_WAIT_MAX)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_lu_cnt    <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_mem_stall || w_load_use) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_load_use && (r_lu_cnt != '1)) begin
                r_lu_cnt <= r_lu_cnt + c_CNT_ONE;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign Mem_Timeout_o = r_timeout;
    assign Stall_Cnt_o   = r_stall_cnt;
    assign LoadUse_Cnt_o = r_lu_cnt;
    assign Flush_Cnt_o   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Brief    : Directed vector table plus multi-cycle sequences for
//            hazard_stall_unit (TIMEOUT_CYC=4, CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_hazard_stall_unit;

    localparam int c_TIMEOUT = 4;
    localparam int c_CW      = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      rs1, rs2, rd;
    logic            use1, use2, mrd, br, req, rdy;
    logic            pc_w, ifid_w, ifid_f, idex_b, exmem_w, memwb_b, tmo;
    logic [c_CW-1:0] stall_cnt, lu_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit #(.TIMEOUT_CYC(c_TIMEOUT), .CNT_W(c_CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .ID_Rs1_i(rs1), .ID_Rs2_i(rs2), .ID_UseRs1_i(use1), .ID_UseRs2_i(use2),
        .EX_MemRead_i(mrd), .EX_Rd_i(rd), .ID_BranchTaken_i(br),
        .MEM_Req_i(req), .MEM_Ready_i(rdy),
        .PC_Write_o(pc_w), .IFID_Write_o(ifid_w), .IFID_Flush_o(ifid_f),
        .IDEX_Bubble_o(idex_b), .EXMEM_Write_o(exmem_w), .MEMWB_Bubble_o(memwb_b),
        .Mem_Timeout_o(tmo), .Stall_Cnt_o(stall_cnt), .LoadUse_Cnt_o(lu_cnt),
        .Flush_Cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    // exp = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble}
    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       mrd;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [5:0] ctl();
        return {pc_w, ifid_w, ifid_f, idex_b, exmem_w, memwb_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; mrd = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110010};
        vecs[1]  = '{1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 6'b000110};
        vecs[2]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110010};
        vecs[3]  = '{1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 6'b110010};
        vecs[4]  = '{1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 6'b000110};
        vecs[5]  = '{1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 6'b111010};
        vecs[6]  = '{1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 6'b000110};
        vecs[7]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b000001};
        vecs[8]  = '{1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 6'b000001};
        vecs[9]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 6'b110010};
        vecs[10] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 6'b111010};
        vecs[11] = '{1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 6'b001101};

        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        check("reset_lu_cnt", 32'(lu_cnt), 0);
        check("reset_flush_cnt", 32'(flush_cnt), 0);
        check("reset_timeout", 32'(tmo), 0);
        check("reset_state", 32'(dut.r_state), 0);

        for (int i = 0; i < 12; i++) begin
            rst  = vecs[i].rst;
            rs1  = vecs[i].rs1;  rs2  = vecs[i].rs2;
            use1 = vecs[i].use1; use2 = vecs[i].use2;
            mrd  = vecs[i].mrd;  rd   = vecs[i].rd;
            br   = vecs[i].br;   req  = vecs[i].req; rdy = vecs[i].rdy;
            #2;
            check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp));
            tick();
        end

        // Load-use then rd=0 non-hazard
        do_reset();
        mrd = 1'b1; rd = 5'd5; rs2 = 5'd5; use2 = 1'b1;
        tick();
        clear_in();
        check("lu_lu_cnt", 32'(lu_cnt), 1);
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        mrd = 1'b1; rd = 5'd0; rs2 = 5'd0; use2 = 1'b1;
        #2;
        check("rd0_pc_write", 32'(pc_w), 1);
        tick();
        clear_in();
        check("rd0_lu_cnt", 32'(lu_cnt), 1);

        // Branch flush
        br = 1'b1;
        tick();
        clear_in();
        check("br_flush_cnt", 32'(flush_cnt), 1);
        check("br_stall_cnt", 32'(stall_cnt), 1);

        // All three at once: freeze only
        req = 1'b1; mrd = 1'b1; rd = 5'd6; rs1 = 5'd6; use1 = 1'b1; br = 1'b1;
        #2;
        check("prio_ctl", 32'(ctl()), 32'(6'b000001));
        tick();
        clear_in();
        check("prio_stall_cnt", 32'(stall_cnt), 2);
        check("prio_lu_cnt", 32'(lu_cnt), 2);
        check("prio_flush_cnt", 32'(flush_cnt), 1);

        // Memory wait of 3 cycles
        do_reset();
        req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("wait%0d_pc_write", k), 32'(pc_w), 0);
            tick();
        end
        rdy = 1'b1;
        #2;
        check("release_ctl", 32'(ctl()), 32'(6'b110010));
        tick();
        clear_in();
        check("wait_stall_cnt", 32'(stall_cnt), 3);
        check("wait_state_run", 32'(dut.r_state), 0);
        check("wait_no_timeout", 32'(tmo), 0);

        // Timeout after the 4th wait edge, sticky until reset
        do_reset();
        req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("tmo_edge%0d", k), 32'(tmo), (k >= 4) ? 1 : 0);
        end
        rdy = 1'b1;
        tick();
        clear_in();
        tick();
        check("tmo_sticky", 32'(tmo), 1);
        check("tmo_stall_cnt", 32'(stall_cnt), 6);
        do_reset();
        check("tmo_cleared", 32'(tmo), 0);

        // Request dropped without ready: back to RUN, no error
        req = 1'b1;
        tick();
        tick();
        check("drop_state_wait", 32'(dut.r_state), 1);
        req = 1'b0;
        tick();
        check("drop_state_run", 32'(dut.r_state), 0);
        check("drop_no_timeout", 32'(tmo), 0);

        // Reset mid-WAIT
        req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #2;
        check("midrst_ctl", 32'(ctl()), 32'(6'b001101));
        tick();
        check("midrst_state", 32'(dut.r_state), 0);
        check("midrst_stall_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;
        clear_in();

        // Saturation: 20 load-use cycles on a 4-bit counter
        do_reset();
        mrd = 1'b1; rd = 5'd7; rs1 = 5'd7; use1 = 1'b1;
        repeat (20) tick();
        clear_in();
        check("sat_lu_cnt", 32'(lu_cnt), 15);
        check("sat_stall_cnt", 32'(stall_cnt), 15);
        tick();
        check("sat_hold", 32'(lu_cnt), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage RISC-V pipeline. It is the counterpart to the EX-stage forwarding path. Forwarding resolves hazards whose data already exists in EX/MEM or MEM/WB. This block handles the cases forwarding cannot: load-use dependencies, taken-branch flushes in ID, and multi-cycle data-memory waits. It drives the pipeline-register write enables and bubble/flush controls, watches memory waits for a timeout, and keeps saturating performance counters.

## Interface
- TIMEOUT_CYC, 64: memory-wait cycles before a timeout is flagged (≥2).
- CNT_W, 16: width of each performance counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- ID_Rs1_i  in  5  rs1 of the instruction in ID.
- ID_Rs2_i  in  5  rs2 of the instruction in ID.
- ID_UseRs1_i  in  1  ID instruction reads rs1.
- ID_UseRs2_i  in  1  ID instruction reads rs2.
- EX_MemRead_i  in  1  EX instruction is a load.
- EX_Rd_i  in  5  rd of the EX instruction.
- ID_BranchTaken_i  in  1  branch/jump resolved taken in ID.
- MEM_Req_i  in  1  MEM stage has a data-memory access this cycle.
- MEM_Ready_i  in  1  data memory completes the access this cycle.
- PC_Write_o  out  1  PC update enable.
- IFID_Write_o  out  1  IF/ID register write enable.
- IFID_Flush_o  out  1  zero the IF/ID register on this edge.
- IDEX_Bubble_o  out  1  load NOP control into ID/EX.
- EXMEM_Write_o  out  1  ID/EX and EX/MEM write enable.
- MEMWB_Bubble_o  out  1  load NOP control into MEM/WB.
- Mem_Timeout_o  out  1  sticky: a memory wait reached TIMEOUT_CYC.
- Stall_Cnt_o  out  CNT_W  total frozen-or-stalled cycles.
- LoadUse_Cnt_o  out  CNT_W  load-use stall cycles.
- Flush_Cnt_o  out  CNT_W  IF/ID flushes issued.

## Operation
- Hazard conditions, all combinational:
  - **mem_stall** = MEM_Req_i & ~MEM_Ready_i.
  - **load_use** = EX_MemRead_i & (EX_Rd_i≠0) & ((ID_UseRs1_i & ID_Rs1_i==EX_Rd_i) | (ID_UseRs2_i & ID_Rs2_i==EX_Rd_i)).
- Priority is mem_stall > load_use > branch flush. At most one action applies per cycle.
- Default outputs (no hazard): all write enables 1; IFID_Flush_o, IDEX_Bubble_o, MEMWB_Bubble_o all 0.
- mem_stall (full freeze):
  - PC_Write_o=0, IFID_Write_o=0, EXMEM_Write_o=0, MEMWB_Bubble_o=1.
  - IDEX_Bubble_o=0 and IFID_Flush_o=0; flush and load_use are suppressed.
- load_use (with no mem_stall):
  - PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; other controls at default.
  - A branch in ID that depends on the load is not flushed this cycle.
- ID_BranchTaken_i (with no mem_stall and no load_use): IFID_Flush_o=1; all else at default.
- FSM with two states, RUN and WAIT:
  - RUN → WAIT when mem_stall; the wait counter loads 1.
  - WAIT stays in WAIT while mem_stall; the wait counter increments and saturates at TIMEOUT_CYC.
  - WAIT → RUN when ~mem_stall; the wait counter clears to 0.
  - When MEM_Req_i drops without MEM_Ready_i in WAIT, the FSM returns to RUN and no error is flagged.
- Mem_Timeout_o is set on the edge where the wait counter would reach TIMEOUT_CYC. It stays set until rst_i.
- Counters are CNT_W bits, saturate at all-ones, and never wrap:
  - Stall_Cnt_o increments on every cycle with mem_stall or load_use.
  - LoadUse_Cnt_o increments on load_use cycles (not masked by mem_stall).
  - Flush_Cnt_o increments on cycles where IFID_Flush_o=1.
- While rst_i=1, all control outputs are forced combinationally: PC_Write_o=0, IFID_Write_o=0, EXMEM_Write_o=0, IFID_Flush_o=1, IDEX_Bubble_o=1, MEMWB_Bubble_o=1.

## Timing
- All control outputs are combinational from the current inputs and rst_i. They take effect at the same rising edge as the pipeline registers they gate, so latency is 0 cycles.
- FSM state, wait counter, Mem_Timeout_o and all counters are registered and update on the rising clk_i edge.
- Reset values: state RUN, wait counter 0, Mem_Timeout_o=0, all counters 0.
- Asserting rst_i in the middle of a WAIT returns the FSM to RUN and clears all registered state on that edge.
- A memory access with MEM_Ready_i=1 in the same cycle as MEM_Req_i costs 0 stall cycles and does not enter WAIT.
- A load-use hazard causes exactly 1 stall cycle. On the next cycle EX holds the bubble, so load_use deasserts unaided.

## Test plan
- Load-use: EX_MemRead_i=1, EX_Rd_i=5, ID_Rs2_i=5, ID_UseRs2_i=1 for one cycle → PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; LoadUse_Cnt_o=1, Stall_Cnt_o=1. Repeat with EX_Rd_i=0 → no stall.
- Branch: ID_BranchTaken_i=1 with no other hazard → IFID_Flush_o=1 with all write enables 1; Flush_Cnt_o increments by 1.
- Priority: mem_stall, load_use and branch asserted together for one cycle → freeze outputs only; IFID_Flush_o=0, IDEX_Bubble_o=0; Stall_Cnt_o+1, LoadUse_Cnt_o+1, Flush_Cnt_o unchanged.
- Memory wait: MEM_Req_i=1, MEM_Ready_i=0 for 3 cycles, then Ready=1 → freeze for 3 cycles, release on the 4th; Stall_Cnt_o=3; FSM back in RUN.
- Timeout: TIMEOUT_CYC=4, hold mem_stall for 6 cycles → Mem_Timeout_o rises after the 4th wait edge, stays 1 after release, and clears only on rst_i.
- Saturation and reset: CNT_W=4, 20 load-use cycles → LoadUse_Cnt_o=15. Assert rst_i mid-WAIT → counters 0, state RUN, reset control values driven.
